// File: rtl/param_uart.sv
// param_uart: FIFO-buffered UART (TX/RX FSMs, FWFT RX FIFO, sticky overrun).
// Define PARAM_UART_PARITY_EN to generate and check parity per parity_mode.
module param_uart #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUDRATE        = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic                 TX,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic [1:0]           r_err,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [1:0]           parity_mode,
  output logic                 overrun
);
`ifdef PARAM_UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DIV = CLK_FREQ / BAUDRATE;
  localparam int CW = $clog2(DIV);
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [DATA_BITS-1:0] tmem [DEPTH];
  logic [DATA_BITS+1:0] rmem [DEPTH];
  logic [AW:0] tw, tr, rw, rr;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_wr, rx_pop;
  assign tx_empty = tw == tr;
  assign tx_full = (tw[AW] != tr[AW]) && (tw[AW-1:0] == tr[AW-1:0]);
  assign rx_empty = rw == rr;
  assign rx_full = (rw[AW] != rr[AW]) && (rw[AW-1:0] == rr[AW-1:0]);
  assign w_ready = !tx_full;
  assign r_ready = !rx_empty;
  assign tx_push = w_valid && w_ready;
  assign rx_pop = r_valid && r_ready;
  assign r_data = r_ready ? rmem[rr[AW-1:0]][DATA_BITS-1:0] : '0;
  assign r_err = r_ready ? rmem[rr[AW-1:0]][DATA_BITS+1:DATA_BITS] : 2'b00;
  state_t ts, ts_n;
  logic [CW-1:0] tc, tc_n;
  logic [3:0] ti, ti_n;
  logic [DATA_BITS-1:0] tsh, tsh_n;
  logic tp, tp_n, tpen, tpen_n, t_end;
  assign t_end = tc == BIT_END;
  always_comb begin
    ts_n = ts;
    tc_n = tc + 1'b1;
    ti_n = ti;
    tsh_n = tsh;
    tp_n = tp;
    tpen_n = tpen;
    tx_pop = 1'b0;
    case (ts)
      IDLE: tc_n = '0;
      START: if (t_end) begin ts_n = DATA; tc_n = '0; ti_n = '0; end
      DATA: if (t_end) begin
        tc_n = '0;
        tsh_n = tsh >> 1;
        ti_n = ti + 4'd1;
        if (ti == 4'(DATA_BITS - 1)) begin ti_n = '0; ts_n = tpen ? PARITY : STOP; end
      end
      PARITY: if (t_end) begin ts_n = STOP; tc_n = '0; end
      STOP: if (t_end) begin
        tc_n = '0;
        ti_n = ti + 4'd1;
        if (ti == 4'(STOP_BITS - 1)) begin ti_n = '0; ts_n = IDLE; end
      end
      default: ts_n = IDLE;
    endcase
    // a waiting word starts its frame the cycle after the last stop bit, so frames run gap-free
    if (!tx_empty && (ts == IDLE || (ts == STOP && t_end && ti == 4'(STOP_BITS - 1)))) begin
      ts_n = START;
      tc_n = '0;
      ti_n = '0;
      tx_pop = 1'b1;
      tsh_n = tmem[tr[AW-1:0]];
      tpen_n = PAR_EN && (parity_mode == 2'b01 || parity_mode == 2'b10);
      tp_n = ^tmem[tr[AW-1:0]] ^ parity_mode[1];
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      ts <= IDLE;
      tc <= '0;
      ti <= '0;
      tsh <= '0;
      tp <= 1'b0;
      tpen <= 1'b0;
      TX <= 1'b1;
    end else begin
      ts <= ts_n;
      tc <= tc_n;
      ti <= ti_n;
      tsh <= tsh_n;
      tp <= tp_n;
      tpen <= tpen_n;
      TX <= (ts == START) ? 1'b0 : (ts == DATA) ? tsh[0] : (ts == PARITY) ? tp : 1'b1;
    end
  end
  state_t rs, rs_n;
  logic [2:0] rx_q;
  logic [CW-1:0] rc, rc_n;
  logic [3:0] ri, ri_n;
  logic [DATA_BITS-1:0] rsh, rsh_n;
  logic rpen, rpen_n, rodd, rodd_n, rferr, rferr_n, rperr, rperr_n, rpush, rpush_q, r_end, rx_s;
  assign rx_s = rx_q[1];
  assign r_end = rc == BIT_END;
  always_comb begin
    rs_n = rs;
    rc_n = rc + 1'b1;
    ri_n = ri;
    rsh_n = rsh;
    rpen_n = rpen;
    rodd_n = rodd;
    rferr_n = rferr;
    rperr_n = rperr;
    rpush = 1'b0;
    case (rs)
      IDLE: begin
        rc_n = '0;
        if (rx_q[2] && !rx_s) begin
          rs_n = START;
          rpen_n = PAR_EN && (parity_mode == 2'b01 || parity_mode == 2'b10);
          rodd_n = parity_mode[1];
          rperr_n = 1'b0;
        end
      end
      START: if (rc == HALF_END) begin rc_n = '0; ri_n = '0; rs_n = rx_s ? IDLE : DATA; end
      DATA: if (r_end) begin
        rc_n = '0;
        rsh_n = {rx_s, rsh[DATA_BITS-1:1]};
        ri_n = ri + 4'd1;
        if (ri == 4'(DATA_BITS - 1)) rs_n = rpen ? PARITY : STOP;
      end
      PARITY: if (r_end) begin rc_n = '0; rperr_n = rx_s ^ (^rsh) ^ rodd; rs_n = STOP; end
      STOP: if (r_end) begin rs_n = IDLE; rferr_n = !rx_s; rpush = 1'b1; end
      default: rs_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rs <= IDLE;
      rx_q <= 3'b111;
      rc <= '0;
      ri <= '0;
      rsh <= '0;
      rpen <= 1'b0;
      rodd <= 1'b0;
      rferr <= 1'b0;
      rperr <= 1'b0;
      rpush_q <= 1'b0;
    end else begin
      rs <= rs_n;
      rx_q <= {rx_q[1:0], RX};
      rc <= rc_n;
      ri <= ri_n;
      rsh <= rsh_n;
      rpen <= rpen_n;
      rodd <= rodd_n;
      rferr <= rferr_n;
      rperr <= rperr_n;
      rpush_q <= rpush;
    end
  end
  assign rx_wr = rpush_q && !rx_full;
  always_ff @(posedge CLK) begin
    if (tx_push) tmem[tw[AW-1:0]] <= w_data;
    if (rx_wr) rmem[rw[AW-1:0]] <= {rperr, rferr, rsh};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tw <= '0;
      tr <= '0;
      rw <= '0;
      rr <= '0;
      overrun <= 1'b0;
    end else begin
      tw <= tw + (AW+1)'(tx_push);
      tr <= tr + (AW+1)'(tx_pop);
      rw <= rw + (AW+1)'(rx_wr);
      rr <= rr + (AW+1)'(rx_pop);
      overrun <= (rpush_q && rx_full) || (overrun && !rx_pop);
    end
  end
endmodule

// File: tb/tb_param_uart.sv
// tb_param_uart: directed bench for param_uart with an RX scoreboard drained by a monitor.
// Expectations follow PARAM_UART_PARITY_EN when it is defined for the build.
module tb_param_uart;
`ifdef PARAM_UART_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif
  localparam int DIV = 32;
  localparam int FL = (10 + int'(PB)) * DIV;
  logic CLK = 1'b0, RST = 1'b1, rx_drv = 1'b1, lb = 1'b0;
  logic w_valid = 1'b0, r_valid = 1'b0, r_ready, w_ready, overrun, tx;
  logic [7:0] w_data = '0, r_data;
  logic [1:0] r_err, parity_mode = 2'b00;
  logic rx_line;
  int checks = 0, errors = 0;
  logic [9:0] exp_q[$];
  assign rx_line = lb ? tx : rx_drv;
  always #5 CLK = ~CLK;
  param_uart #(.CLK_FREQ(3_200_000), .BAUDRATE(100_000), .DATA_BITS(8), .STOP_BITS(1),
               .FIFO_ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST), .RX(rx_line), .TX(tx), .w_data(w_data), .w_valid(w_valid),
    .w_ready(w_ready), .r_data(r_data), .r_err(r_err), .r_valid(r_valid), .r_ready(r_ready),
    .parity_mode(parity_mode), .overrun(overrun));
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv);
    logic pen;
    pen = PB && (parity_mode == 2'b01 || parity_mode == 2'b10);
    rx_drv = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(DIV);
    end
    if (pen) begin
      rx_drv = (^d) ^ parity_mode[1] ^ pflip;
      step(DIV);
    end
    rx_drv = stopv;
    step(DIV);
    rx_drv = 1'b1;
    step(2 * DIV);
  endtask
  task automatic drain(input string name);
    for (int n = 0; n < 4 * FL && exp_q.size() != 0; n++) step(1);
    step(4);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK);
      if (!RST && r_valid && r_ready) begin
        if (exp_q.size() == 0) check("rx_unexpected", 32'({r_err, r_data}), 32'h3ff);
        else begin
          e = exp_q.pop_front();
          check("rx_word", 32'({r_err, r_data}), 32'(e));
        end
      end
    end
  end
  initial begin
    int t, lows;
    logic [7:0] d;
    step(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_r_ready", 32'(r_ready), 32'd0);
    check("rst_r_err", 32'(r_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    RST = 1'b0;
    step(1);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_r_ready", 32'(r_ready), 32'd0);
    d = 8'hA5;
    w_data = d;
    w_valid = 1'b1;
    step(1);
    w_valid = 1'b0;
    step(1);
    check("tx_lat1", 32'(tx), 32'd1);
    step(1);
    for (int j = 0; j < 10; j++) begin
      check("tx_bit_first", 32'(tx), (j == 0) ? 32'd0 : (j == 9) ? 32'd1 : 32'(d[j-1]));
      step(DIV - 1);
      check("tx_bit_last", 32'(tx), (j == 0) ? 32'd0 : (j == 9) ? 32'd1 : 32'(d[j-1]));
      step(1);
    end
    check("tx_idle_after", 32'(tx), 32'd1);
    step(2 * DIV);
    check("tx_idle_later", 32'(tx), 32'd1);
    lb = 1'b1;
    parity_mode = 2'b01;
    r_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_data = 8'(i);
      w_valid = 1'b1;
      exp_q.push_back({2'b00, 8'(i)});
      step(1);
    end
    w_valid = 1'b0;
    t = 7;
    for (int k = 1; k < 8; k++) begin
      step(2 + k * FL - 1 - t);
      check("lb_stop_before", 32'(tx), 32'd1);
      step(1);
      check("lb_start_nogap", 32'(tx), 32'd0);
      t = 2 + k * FL;
    end
    drain("lb_all_received");
    lb = 1'b0;
    step(DIV);
    rx_drv = 1'b0;
    step(DIV / 4);
    rx_drv = 1'b1;
    step(3 * DIV);
    check("glitch_r_ready", 32'(r_ready), 32'd0);
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0);
    parity_mode = 2'b10;
    exp_q.push_back({PB ? 2'b10 : 2'b00, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b1);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1);
    drain("err_all_received");
    r_valid = 1'b0;
    parity_mode = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({2'b00, 8'(8'h40 + i)});
      send_frame(8'(8'h40 + i), 1'b0, 1'b1);
    end
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_r_ready", 32'(r_ready), 32'd1);
    r_valid = 1'b1;
    step(1);
    r_valid = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    check("ovr_queue_left", 32'(exp_q.size()), 32'd7);
    r_valid = 1'b1;
    drain("ovr_remaining_seven");
    r_valid = 1'b0;
    check("ovr_empty", 32'(r_ready), 32'd0);
    w_data = 8'h00;
    w_valid = 1'b1;
    step(9);
    check("tx_fifo_full", 32'(w_ready), 32'd0);
    w_valid = 1'b0;
    step(4 * DIV + DIV / 2);
    check("abort_tx_before", 32'(tx), 32'd0);
    RST = 1'b1;
    step(1);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_w_ready", 32'(w_ready), 32'd1);
    RST = 1'b0;
    lows = 0;
    for (int n = 0; n < 3 * FL; n++) begin
      step(1);
      if (!tx) lows++;
    end
    check("abort_no_activity", 32'(lows), 32'd0);
    check("abort_r_ready", 32'(r_ready), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
